// File: rtl/conv_output_collector.sv
// -----------------------------------------------------------------------------
// conv_output_collector
//
// Output stage of the convolver. Accepts one signed accumulator per pixel of a
// WIDTH x HEIGHT frame, drops results whose KERN_DIM x KERN_DIM window touches
// the image border, scales (arithmetic shift) and saturates the kept results,
// and buffers them in a small FIFO presented over a valid/ready interface.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse, starts a frame from IDLE
//   in_valid   / in_ready / in_data    accumulator input handshake
//   out_valid  / out_ready / out_data  scaled result output handshake
//   out_last   marks the final result of the frame
//   busy       high while a frame is being collected or drained
//   frame_done one-cycle pulse once the frame has fully drained
//
// Build option: define RELU_EN to clamp negative scaled values to zero
// before saturation.
// -----------------------------------------------------------------------------
module conv_output_collector #(
  parameter int KERN_DIM   = 3,
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int ACC_BW     = 24,
  parameter int OUT_BW     = 8,
  parameter int FRAC_SHIFT = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_BW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_BW-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_KEEP = COL_W'(KERN_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_KEEP = ROW_W'(KERN_DIM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Saturation bounds sign-extended to the accumulator width.
  localparam logic signed [ACC_BW-1:0] SAT_MAX =
    {{(ACC_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN =
    {{(ACC_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  // Shift, optional ReLU, then clamp into the signed output range.
  function automatic logic [OUT_BW-1:0] sat_scale(input logic signed [ACC_BW-1:0] acc);
    logic signed [ACC_BW-1:0] s;
    s = acc >>> FRAC_SHIFT;
`ifdef RELU_EN
    if (s[ACC_BW-1]) s = {ACC_BW{1'b0}};
    else             s = s;
`endif
    if (s > SAT_MAX)      sat_scale = SAT_MAX[OUT_BW-1:0];
    else if (s < SAT_MIN) sat_scale = SAT_MIN[OUT_BW-1:0];
    else                  sat_scale = s[OUT_BW-1:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_BW:0]  head_q, head_d;       // {last, data} of the oldest entry
  logic             frame_done_q, frame_done_d;
  logic [OUT_BW:0]  mem_q [FIFO_DEPTH];

  logic fifo_full_s, fifo_empty_s, accept_s, pop_s, keep_s, at_last_s, push_s;
  logic [OUT_BW:0] push_word_s;

  assign fifo_full_s  = (count_q == CNT_FULL);
  assign fifo_empty_s = (count_q == CNT_W'(0));
  // Full blocks input even when a pop happens in the same cycle.
  assign in_ready     = (state_q == ST_ACTIVE) && !fifo_full_s;
  assign out_valid    = !fifo_empty_s;
  assign accept_s     = in_valid && in_ready;
  assign pop_s        = out_valid && out_ready;
  assign keep_s       = (col_q >= COL_KEEP) && (row_q >= ROW_KEEP);
  assign at_last_s    = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign push_s       = accept_s && keep_s;
  assign push_word_s  = {at_last_s, sat_scale(in_data)};
  assign rd_next_s    = rd_ptr_q + PTR_W'(1);

  assign out_data   = head_q[OUT_BW-1:0];
  assign out_last   = head_q[OUT_BW];
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

  // Frame FSM and pixel position counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          col_d   = COL_W'(0);
          row_d   = ROW_W'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (accept_s) begin
          if (col_q == COL_LAST) begin
            col_d = COL_W'(0);
            if (row_q == ROW_LAST) begin
              row_d   = ROW_W'(0);
              state_d = ST_FLUSH;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty_s) state_d = ST_IDLE;
        else              state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and the first-word output register.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_next_s              : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head advances to the next stored entry on a pop, or loads the incoming
    // word when it becomes the oldest one; otherwise it holds (also when empty).
    if (pop_s && (count_q > CNT_W'(1)))
      head_d = mem_q[rd_next_s];
    else if (push_s && (fifo_empty_s || (pop_s && (count_q == CNT_W'(1)))))
      head_d = push_word_s;
    else
      head_d = head_q;
    // Pulse in the first cycle that FLUSH sees an empty FIFO.
    frame_done_d = (state_d == ST_FLUSH) && (count_d == CNT_W'(0));
  end

  // State and FIFO control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= COL_W'(0);
      row_q        <= ROW_W'(0);
      wr_ptr_q     <= PTR_W'(0);
      rd_ptr_q     <= PTR_W'(0);
      count_q      <= CNT_W'(0);
      head_q       <= {(OUT_BW+1){1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= push_word_s;
  end

endmodule

// File: tb/tb_conv_output_collector.sv
module tb_conv_output_collector;

  localparam int W = 28;
  localparam int H = 28;
  localparam int K = 3;
  localparam int NPIX = W * H;
  localparam int NKEEP = (W - K + 1) * (H - K + 1);

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready;
  logic        out_last, busy, frame_done;
  logic [23:0] in_data;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  conv_output_collector dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cnt, pops, fd_cnt, last_pop_cyc;
  bit          drv_done, abort;
  logic [8:0]  exp_q[$];
  logic [23:0] sat_in[8];
  logic [7:0]  sat_out[8];
  bit          stall_v = 1'b0;
  logic [8:0]  stall_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops expected words whenever the DUT hands out a result.
  always @(negedge clk) begin
    logic [8:0] w;
    if (out_valid && stall_v) check("hold_stable", {out_last, out_data}, stall_w);
    stall_v = out_valid && !out_ready;
    stall_w = {out_last, out_data};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {out_last, out_data}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("pop_data", {out_last, out_data}, w);
      end
      pops++;
      if (out_last) last_pop_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      check("done_after_last", cyc, last_pop_cyc + 1);
    end
  end

  // Driver: walks the frame, pushes the expected word for each kept accept.
  task automatic drive_frame(input int sel);
    int p = 0;
    int k = 0;
    int guard = 0;
    int r, c;
    bit kept;
    logic [23:0] v;
    logic [7:0]  e;
    drv_done = 1'b0;
    while (p < NPIX && !abort && guard < 20000) begin
      r = p / W;
      c = p % W;
      kept = (r >= K - 1) && (c >= K - 1);
      if (!kept) begin
        v = 24'h7FFFFF;
        e = 8'h00;
      end else if (sel == 0) begin
        v = 24'(16 * (k % 8));
        e = 8'(k % 8);
      end else begin
        v = sat_in[k % 8];
        e = sat_out[k % 8];
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      if (in_ready) begin
        acc_cnt++;
        if (kept) begin
          exp_q.push_back({(p == NPIX - 1), e});
          k++;
        end
        p++;
      end
      guard++;
    end
    if (guard >= 20000) check("drv_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drv_done = 1'b1;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 6000);
    check(name, frame_done, 1);
  endtask

  task automatic wait_drv(input string name);
    int n = 0;
    while (!drv_done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check(name, drv_done, 1);
  endtask

  task automatic new_frame_counts();
    pops = 0; fd_cnt = 0; acc_cnt = 0;
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 24'h0; out_ready = 1'b0;
    abort = 1'b0; drv_done = 1'b0; acc_cnt = 0; pops = 0; fd_cnt = 0; last_pop_cyc = -10;
    // Hand-computed saturation vectors: >>>4 then clamp to [-128,127].
    sat_in[0] = 24'h7FFFFF; sat_out[0] = 8'h7F;
    sat_in[1] = 24'h800000; sat_out[1] = 8'h80;
    sat_in[2] = 24'h000070; sat_out[2] = 8'h07;
    sat_in[3] = 24'hFFFFF0; sat_out[3] = 8'hFF;
    sat_in[4] = 24'h0007F0; sat_out[4] = 8'h7F;
    sat_in[5] = 24'h000800; sat_out[5] = 8'h7F;
    sat_in[6] = 24'hFFF800; sat_out[6] = 8'h80;
    sat_in[7] = 24'hFFF7F0; sat_out[7] = 8'h80;
`ifdef RELU_EN
    sat_out[1] = 8'h00; sat_out[3] = 8'h00; sat_out[6] = 8'h00; sat_out[7] = 8'h00;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b1;

    // Frame 1: full frame, consumer always ready
    @(posedge clk); #1 out_ready = 1'b1;
    new_frame_counts();
    start_pulse();
    fork drive_frame(0); join_none
    wait_done("f1_done");
    @(negedge clk);
    check("f1_pops", pops, NKEEP);
    check("f1_done_cnt", fd_cnt, 1);
    check("f1_done_one_cycle", frame_done, 0);
    check("f1_idle", busy, 0);
    check("empty_out_valid", out_valid, 0);
    check("empty_hold_data", out_data, 3);
    check("f1_queue_empty", exp_q.size(), 0);

    // Frame 2: saturation vectors with random backpressure
    new_frame_counts();
    start_pulse();
    fork drive_frame(1); join_none
    n = 0;
    do begin
      @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n++;
    end while (!frame_done && n < 8000);
    check("f2_done", frame_done, 1);
    @(negedge clk);
    check("f2_pops", pops, NKEEP);
    check("f2_done_cnt", fd_cnt, 1);
    check("f2_queue_empty", exp_q.size(), 0);

    // Frame 3: full FIFO, push/pop at 7 entries, start ignored while busy
    @(posedge clk); #1 out_ready = 1'b0;
    new_frame_counts();
    start_pulse();
    fork drive_frame(0); join_none
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_counters_frozen", acc_cnt, 66);
    check("bp_busy", busy, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_no_pass", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_pop", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("pushpop_keeps_7", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("refull", in_ready, 0);
    check("refull_accepts", acc_cnt, 68);
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (acc_cnt < 780 && n < 3000);
    out_ready = 1'b0;
    wait_drv("f3_drv_done");
    start_pulse();
    @(negedge clk);
    check("flush_start_busy", busy, 1);
    check("flush_start_in_ready", in_ready, 0);
    check("flush_holds_data", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("f3_done");
    @(negedge clk);
    check("f3_pops", pops, NKEEP);
    check("f3_done_cnt", fd_cnt, 1);

    // Frame 4: reset after 400 accepts
    new_frame_counts();
    start_pulse();
    fork drive_frame(0); join_none
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (acc_cnt < 400 && n < 3000);
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_in_ready", in_ready, 0);
    abort = 1'b1;
    wait_drv("f4_drv_abort");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", fd_cnt, 0);

    // Frame 5: clean frame after the mid-frame reset
    new_frame_counts();
    start_pulse();
    fork drive_frame(0); join_none
    wait_done("f5_done");
    @(negedge clk);
    check("f5_pops", pops, NKEEP);
    check("f5_done_cnt", fd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
